data_path: RTL and testbench

//  32-bit bus-based datapath of the RISC CPU; the control unit (or a bench) drives one-hot control strobes.

---
 rtl/data_path_pkg.sv | 22 ++
 rtl/data_path_alu.sv | 59 +++++
 rtl/data_path.sv | 162 ++++++++++++++++
 tb/tb_data_path.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_path_pkg.sv
// Shared widths and ALU opcodes for the CPU datapath and its ALU.
package data_path_pkg;

   localparam int WIDTH     = 32;
   localparam int MEM_WORDS = 512;
   localparam int ADDR_W    = $clog2(MEM_WORDS);

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_AND  = 5'd2;
   localparam logic [4:0] ALU_OR   = 5'd3;
   localparam logic [4:0] ALU_SHR  = 5'd4;
   localparam logic [4:0] ALU_SHRA = 5'd5;
   localparam logic [4:0] ALU_SHL  = 5'd6;
   localparam logic [4:0] ALU_ROR  = 5'd7;
   localparam logic [4:0] ALU_ROL  = 5'd8;
   localparam logic [4:0] ALU_MUL  = 5'd9;
   localparam logic [4:0] ALU_DIV  = 5'd10;
   localparam logic [4:0] ALU_NEG  = 5'd11;
   localparam logic [4:0] ALU_NOT  = 5'd12;

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result feeds Z.
module data_path_alu
   import data_path_pkg::*;
(
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [4:0]         alu_control,
   output logic [2*WIDTH-1:0] r
);

   logic [4:0]           sh;
   logic [5:0]           sh_inv;
   logic [2*WIDTH-1:0]   a_ext;
   logic [2*WIDTH-1:0]   b_ext;
   logic signed [WIDTH-1:0] quot;
   logic signed [WIDTH-1:0] rem;

   assign sh     = b[4:0];
   assign sh_inv = 6'd32 - {1'b0, sh};
   assign a_ext  = {{WIDTH{a[WIDTH-1]}}, a};
   assign b_ext  = {{WIDTH{b[WIDTH-1]}}, b};

   // Most-negative / -1 overflows; return the wrapped quotient with zero remainder.
   always_comb begin
      quot = '0;
      rem  = '0;
      if (b == '0) begin
         quot = '1;
         rem  = $signed(a);
      end else if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
         quot = $signed(a);
         rem  = '0;
      end else begin
         quot = $signed(a) / $signed(b);
         rem  = $signed(a) % $signed(b);
      end
   end

   always_comb begin
      r = '0;
      case (alu_control)
         ALU_ADD:  r[WIDTH-1:0] = a + b;
         ALU_SUB:  r[WIDTH-1:0] = a - b;
         ALU_AND:  r[WIDTH-1:0] = a & b;
         ALU_OR:   r[WIDTH-1:0] = a | b;
         ALU_SHR:  r[WIDTH-1:0] = a >> sh;
         ALU_SHRA: r[WIDTH-1:0] = $signed(a) >>> sh;
         ALU_SHL:  r[WIDTH-1:0] = a << sh;
         ALU_ROR:  r[WIDTH-1:0] = (a >> sh) | (a << sh_inv);
         ALU_ROL:  r[WIDTH-1:0] = (a << sh) | (a >> sh_inv);
         ALU_MUL:  r = a_ext * b_ext;
         ALU_DIV:  r = {rem, quot};
         ALU_NEG:  r[WIDTH-1:0] = -b;
         ALU_NOT:  r[WIDTH-1:0] = ~b;
         default:  r = '0;
      endcase
   end

endmodule

// File: rtl/data_path.sv
// Single-bus RISC datapath: register file, PC/IR/MAR/MDR/Y/Z, CON, out-port,
// on-chip RAM and ALU, all steered by one-hot strobes from the control unit.
module data_path
   import data_path_pkg::*;
(
   input  logic       clock,
   input  logic       clear,
   input  logic       PCout,
   input  logic       ZLOout,
   input  logic       ZHIout,
   input  logic       MDRout,
   input  logic       Cout,
   input  logic       Rout,
   input  logic       BAout,
   input  logic       ZMuxOut,
   input  logic       PortInout,
   input  logic       PCin,
   input  logic       MARin,
   input  logic       MDRin,
   input  logic       IRin,
   input  logic       Yin,
   input  logic       Rin,
   input  logic       R15in,
   input  logic       ZLOin,
   input  logic       conin,
   input  logic       OutPortenable,
   input  logic       IncPC,
   input  logic       Gra,
   input  logic       Grb,
   input  logic       Grc,
   input  logic       read,
   input  logic       write,
   input  logic       RAMenable,
   input  logic       ZMuxEnable,
   input  logic       ZSelect,
   input  logic [4:0] aluControl,
   output logic       out
);

   logic [WIDTH-1:0]   gpr_q [16];
   logic [WIDTH-1:0]   gpr_d [16];
   logic [WIDTH-1:0]   pc_q, pc_d;
   logic [WIDTH-1:0]   ir_q, ir_d;
   logic [ADDR_W-1:0]  mar_q, mar_d;
   logic [WIDTH-1:0]   mdr_q, mdr_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic [2*WIDTH-1:0] z_q, z_d;
   logic               con_q, con_d;
   logic [WIDTH-1:0]   outport_q, outport_d;

   logic [WIDTH-1:0]   mem_q [MEM_WORDS];

   logic [3:0]         sel_idx;
   logic [WIDTH-1:0]   sel_val;
   logic [WIDTH-1:0]   ba_val;
   logic [WIDTH-1:0]   c_val;
   logic [WIDTH-1:0]   bus;
   logic [WIDTH-1:0]   mem_rd;
   logic [WIDTH-1:0]   pc_inc;
   logic [2*WIDTH-1:0] alu_r;
   logic               cond;

   always_comb begin
      sel_idx = 4'd0;
      if (Gra)      sel_idx = ir_q[26:23];
      else if (Grb) sel_idx = ir_q[22:19];
      else if (Grc) sel_idx = ir_q[18:15];
   end

   assign sel_val = gpr_q[sel_idx];
   assign ba_val  = (sel_idx == 4'd0) ? '0 : sel_val;
   assign c_val   = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};
   assign mem_rd  = mem_q[mar_q];
   assign pc_inc  = pc_q + 1'b1;

   always_comb begin
      bus = '0;
      if (MDRout)         bus = mdr_q;
      else if (PCout)     bus = pc_q;
      else if (ZHIout)    bus = z_q[2*WIDTH-1:WIDTH];
      else if (ZLOout)    bus = z_q[WIDTH-1:0];
      else if (ZMuxOut)   bus = ZSelect ? z_q[2*WIDTH-1:WIDTH] : z_q[WIDTH-1:0];
      else if (Cout)      bus = c_val;
      else if (Rout)      bus = sel_val;
      else if (BAout)     bus = ba_val;
      else if (PortInout) bus = outport_q;
   end

   data_path_alu u_alu (
      .a           (y_q),
      .b           (bus),
      .alu_control (aluControl),
      .r           (alu_r)
   );

   always_comb begin
      case (ir_q[20:19])
         2'b00:   cond = (bus == '0);
         2'b01:   cond = (bus != '0);
         2'b10:   cond = ~bus[WIDTH-1];
         default: cond = bus[WIDTH-1];
      endcase
   end

   always_comb begin
      gpr_d     = gpr_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      mar_d     = mar_q;
      mdr_d     = mdr_q;
      y_d       = y_q;
      z_d       = z_q;
      con_d     = con_q;
      outport_d = outport_q;

      if (PCin)       pc_d = bus;
      else if (IncPC) pc_d = pc_inc;
      if (IRin)       ir_d = bus;
      if (MARin)      mar_d = bus[ADDR_W-1:0];
      if (Yin)        y_d = bus;
      if (MDRin)      mdr_d = (read && RAMenable) ? mem_rd : bus;
      // Rin is applied last so it wins when it also targets R15.
      if (R15in)      gpr_d[15] = bus;
      if (Rin)        gpr_d[sel_idx] = bus;
      if (ZLOin)           z_d = alu_r;
      else if (ZMuxEnable) z_d = ZSelect ? {{WIDTH{1'b0}}, pc_inc} : alu_r;
      if (conin)         con_d = cond;
      if (OutPortenable) outport_d = bus;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
         pc_q      <= '0;
         ir_q      <= '0;
         mar_q     <= '0;
         mdr_q     <= '0;
         y_q       <= '0;
         z_q       <= '0;
         con_q     <= 1'b0;
         outport_q <= '0;
      end else begin
         gpr_q     <= gpr_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         mar_q     <= mar_d;
         mdr_q     <= mdr_d;
         y_q       <= y_d;
         z_q       <= z_d;
         con_q     <= con_d;
         outport_q <= outport_d;
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clock) begin
      if (write && RAMenable) mem_q[mar_q] <= mdr_q;
   end

   assign out = con_q;

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: constants are built through the datapath itself, results
// are compared against fixed vectors and a behavioural ALU/condition model.
module tb_data_path;
   import data_path_pkg::*;

   logic       clock = 1'b0;
   logic       clear;
   logic       PCout, ZLOout, ZHIout, MDRout, Cout, Rout, BAout, ZMuxOut, PortInout;
   logic       PCin, MARin, MDRin, IRin, Yin, Rin, R15in, ZLOin, conin, OutPortenable;
   logic       IncPC, Gra, Grb, Grc, read, write, RAMenable, ZMuxEnable, ZSelect;
   logic [4:0] aluControl;
   logic       out;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] z;
   } vec_t;

   vec_t vecs[16];

   data_path dut (
      .clock(clock), .clear(clear),
      .PCout(PCout), .ZLOout(ZLOout), .ZHIout(ZHIout), .MDRout(MDRout), .Cout(Cout),
      .Rout(Rout), .BAout(BAout), .ZMuxOut(ZMuxOut), .PortInout(PortInout),
      .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin),
      .R15in(R15in), .ZLOin(ZLOin), .conin(conin), .OutPortenable(OutPortenable),
      .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .read(read), .write(write),
      .RAMenable(RAMenable), .ZMuxEnable(ZMuxEnable), .ZSelect(ZSelect),
      .aluControl(aluControl), .out(out)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      PCout = 0; ZLOout = 0; ZHIout = 0; MDRout = 0; Cout = 0; Rout = 0; BAout = 0;
      ZMuxOut = 0; PortInout = 0; PCin = 0; MARin = 0; MDRin = 0; IRin = 0; Yin = 0;
      Rin = 0; R15in = 0; ZLOin = 0; conin = 0; OutPortenable = 0; IncPC = 0;
      Gra = 0; Grb = 0; Grc = 0; read = 0; write = 0; RAMenable = 0;
      ZMuxEnable = 0; ZSelect = 0; aluControl = 5'd0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Leaves v in Z[31:0] (Z[63:32]=0) and PC=1, by shift-and-add with PC as the constant 1.
   task automatic build(input logic [31:0] v);
      PCin = 1; tick();
      IncPC = 1; tick();
      ZLOin = 1; aluControl = 5'd31; tick();
      for (int i = 31; i >= 0; i--) begin
         ZLOout = 1; Yin = 1; tick();
         PCout = 1; ZLOin = 1; aluControl = ALU_SHL; tick();
         if (v[i]) begin
            ZLOout = 1; Yin = 1; tick();
            PCout = 1; ZLOin = 1; aluControl = ALU_ADD; tick();
         end
      end
   endtask

   task automatic load_y(input logic [31:0] v);
      build(v);
      ZLOout = 1; Yin = 1; tick();
   endtask

   task automatic load_mdr(input logic [31:0] v);
      build(v);
      ZLOout = 1; MDRin = 1; tick();
   endtask

   task automatic load_ir(input logic [31:0] v);
      build(v);
      ZLOout = 1; IRin = 1; tick();
   endtask

   task automatic alu_op(input logic [4:0] op);
      MDRout = 1; aluControl = op; ZLOin = 1; tick();
   endtask

   function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] res;
      logic [63:0] dbl;
      int sh;
      int q;
      int rm;
      sh  = int'(b[4:0]);
      dbl = {a, a};
      res = 64'd0;
      case (op)
         5'd0:  res = {32'd0, a + b};
         5'd1:  res = {32'd0, a - b};
         5'd2:  res = {32'd0, a & b};
         5'd3:  res = {32'd0, a | b};
         5'd4:  res = {32'd0, a >> sh};
         5'd5:  res = {32'd0, 32'($signed(a) >>> sh)};
         5'd6:  res = {32'd0, a << sh};
         5'd7:  begin dbl = dbl >> sh; res = {32'd0, dbl[31:0]}; end
         5'd8:  begin dbl = dbl << sh; res = {32'd0, dbl[63:32]}; end
         5'd9:  res = 64'(longint'($signed(a)) * longint'($signed(b)));
         5'd10: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               q  = int'(a) / int'(b);
               rm = int'(a) % int'(b);
               res = {32'(rm), 32'(q)};
            end
         end
         5'd11: res = {32'd0, 32'd0 - b};
         5'd12: res = {32'd0, ~b};
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   function automatic logic ref_cond(input logic [1:0] c, input logic [31:0] v);
      case (c)
         2'd0:    return v == 32'd0;
         2'd1:    return v != 32'd0;
         2'd2:    return $signed(v) >= 0;
         default: return $signed(v) < 0;
      endcase
   endfunction

   initial begin
      logic [4:0]  op;
      logic [31:0] a, b, v;
      logic [1:0]  c;

      vecs[0]  = '{ALU_MUL,  32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
      vecs[1]  = '{ALU_DIV,  32'd7,          32'hFFFF_FFFD, 64'h0000_0001_FFFF_FFFE};
      vecs[2]  = '{ALU_DIV,  32'd7,          32'd0,         64'h0000_0007_FFFF_FFFF};
      vecs[3]  = '{ALU_DIV,  32'hFFFF_FFF9,  32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
      vecs[4]  = '{ALU_ADD,  32'hFFFF_FFFF,  32'd2,         64'h0000_0000_0000_0001};
      vecs[5]  = '{ALU_SUB,  32'd3,          32'd5,         64'h0000_0000_FFFF_FFFE};
      vecs[6]  = '{ALU_SHRA, 32'h8000_0000,  32'd4,         64'h0000_0000_F800_0000};
      vecs[7]  = '{ALU_SHR,  32'h8000_0000,  32'd4,         64'h0000_0000_0800_0000};
      vecs[8]  = '{ALU_ROR,  32'h0000_0001,  32'd1,         64'h0000_0000_8000_0000};
      vecs[9]  = '{ALU_ROL,  32'h8000_0000,  32'd33,        64'h0000_0000_0000_0001};
      vecs[10] = '{ALU_SHL,  32'h0000_0001,  32'd31,        64'h0000_0000_8000_0000};
      vecs[11] = '{ALU_NEG,  32'd7,          32'd5,         64'h0000_0000_FFFF_FFFB};
      vecs[12] = '{ALU_NOT,  32'd7,          32'd0,         64'h0000_0000_FFFF_FFFF};
      vecs[13] = '{5'd13,    32'd1,          32'd1,         64'h0};
      vecs[14] = '{ALU_AND,  32'hF0F0_1234,  32'h0FF0_FFFF, 64'h0000_0000_00F0_1234};
      vecs[15] = '{ALU_OR,   32'hF000_0000,  32'h0000_000F, 64'h0000_0000_F000_000F};

      idle();
      clear = 1'b0;
      #23;
      chk("reset_pc", {32'd0, dut.pc_q}, 64'd0);
      chk("reset_z", dut.z_q, 64'd0);
      chk("reset_out", {63'd0, out}, 64'd0);
      clear = 1'b1;
      @(posedge clock); #1;

      // Fetch: place the instruction word in RAM[0], then run T0..T2.
      build(32'h1080_0000);
      ZLOout = 1; MDRin = 1; tick();
      MARin = 1; tick();
      write = 1; RAMenable = 1; tick();
      MDRin = 1; tick();
      PCout = 1; MARin = 1; tick();
      PCin = 1; tick();
      chk("setup_mar_nonzero", {55'd0, dut.mar_q}, 64'd1);
      PCout = 1; MARin = 1; IncPC = 1; tick();
      chk("t0_mar", {55'd0, dut.mar_q}, 64'd0);
      chk("t0_pc", {32'd0, dut.pc_q}, 64'd1);
      read = 1; RAMenable = 1; MDRin = 1; tick();
      chk("t1_mdr", {32'd0, dut.mdr_q}, 64'h1080_0000);
      MDRout = 1; IRin = 1; tick();
      chk("t2_ir", {32'd0, dut.ir_q}, 64'h1080_0000);

      // mfhi: 0x1AB / 0x100 leaves Z = {0xAB, 1}; ra of the fetched IR is R1.
      load_mdr(32'h100);
      load_y(32'h1AB);
      alu_op(ALU_DIV);
      chk("mfhi_z", dut.z_q, 64'h0000_00AB_0000_0001);
      ZHIout = 1; Gra = 1; Rin = 1; tick();
      chk("mfhi_r1", {32'd0, dut.gpr_q[1]}, 64'h0000_00AB);
      ZMuxOut = 1; ZSelect = 1; Yin = 1; tick();
      chk("zmux_hi", {32'd0, dut.y_q}, 64'h0000_00AB);
      ZMuxOut = 1; Yin = 1; tick();
      chk("zmux_lo", {32'd0, dut.y_q}, 64'h1);

      foreach (vecs[i]) begin
         load_mdr(vecs[i].b);
         load_y(vecs[i].a);
         alu_op(vecs[i].op);
         chk($sformatf("vec%0d_op%0d", i, vecs[i].op), dut.z_q, vecs[i].z);
      end

      for (int i = 0; i < 24; i++) begin
         op = 5'($urandom_range(0, 15));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         if (op == ALU_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
         load_mdr(b);
         load_y(a);
         alu_op(op);
         chk($sformatf("rand_alu%0d_op%0d", i, op), dut.z_q, ref_alu(op, a, b));
      end

      // Branch on R2 via ra (IR[20:19] stays 00, cond = bus==0).
      load_ir(32'h0100_0000);
      Gra = 1; Rin = 1; tick();
      Gra = 1; Rout = 1; conin = 1; tick();
      chk("branch_zero", {63'd0, out}, 64'd1);
      build(32'd5);
      ZLOout = 1; Gra = 1; Rin = 1; tick();
      Gra = 1; Rout = 1; conin = 1; tick();
      chk("branch_five", {63'd0, out}, 64'd0);

      for (int i = 0; i < 12; i++) begin
         c = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000 | $urandom;
            default: v = $urandom;
         endcase
         load_ir({11'd0, c, 19'd0});
         load_mdr(v);
         MDRout = 1; conin = 1; tick();
         chk($sformatf("rand_con%0d_c%0d", i, c), {63'd0, out}, {63'd0, ref_cond(c, v)});
      end

      // BAout reads R0 as zero, Rout reads its stored value.
      IRin = 1; tick();
      build(32'd9);
      ZLOout = 1; Grb = 1; Rin = 1; tick();
      BAout = 1; Grb = 1; Yin = 1; tick();
      chk("baout_r0", {32'd0, dut.y_q}, 64'd0);
      Rout = 1; Grb = 1; Yin = 1; tick();
      chk("rout_r0", {32'd0, dut.y_q}, 64'd9);

      load_ir(32'h0004_0005);
      Cout = 1; Yin = 1; tick();
      chk("cout_sext", {32'd0, dut.y_q}, 64'hFFFC_0005);

      load_mdr(32'h1234);
      MDRout = 1; PCout = 1; Yin = 1; tick();
      chk("bus_prio_mdr", {32'd0, dut.y_q}, 64'h1234);
      PCout = 1; ZLOout = 1; Yin = 1; tick();
      chk("bus_prio_pc", {32'd0, dut.y_q}, 64'd1);
      ZMuxEnable = 1; ZSelect = 1; tick();
      chk("zmux_pc1", dut.z_q, 64'd2);

      build(32'hCAFE);
      ZLOout = 1; OutPortenable = 1; tick();
      PortInout = 1; Yin = 1; tick();
      chk("outport", {32'd0, dut.y_q}, 64'hCAFE);

      build(32'd77);
      ZLOout = 1; R15in = 1; tick();
      chk("r15in", {32'd0, dut.gpr_q[15]}, 64'd77);

      // Asynchronous reset in the middle of a cycle with state loaded.
      IRin = 1; tick();
      conin = 1; tick();
      IncPC = 1; tick();
      PCout = 1; IRin = 1; ZMuxEnable = 1; ZSelect = 1; tick();
      #3;
      clear = 1'b0;
      #1;
      chk("midreset_pc", {32'd0, dut.pc_q}, 64'd0);
      chk("midreset_ir", {32'd0, dut.ir_q}, 64'd0);
      chk("midreset_z", dut.z_q, 64'd0);
      chk("midreset_out", {63'd0, out}, 64'd0);
      chk("midreset_ram0", {32'd0, dut.mem_q[0]}, 64'h1080_0000);
      #20;
      clear = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
